// File: rtl/jtframe_resync_gen.sv
// Sync re-timer: measures HS/VS position and width per field, then regenerates
// them shifted by signed offsets once lock is reached. Optional: JTFRAME_RESYNC_POLDET_EN.
module jtframe_resync_gen #(
    parameter int BITS        = 4,
    parameter int CNTW        = 10,
    parameter int FIELDS      = 2,
    parameter int HRES_SHIFT  = 1,
    parameter int LOCK_FRAMES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hs_in,
    input  logic            vs_in,
    input  logic            LHBL,
    input  logic            LVBL,
    input  logic [BITS-1:0] hoffset,
    input  logic [BITS-1:0] voffset,
    input  logic            hres_mode,
    input  logic            out_pol,
    output logic            hs_out,
    output logic            vs_out,
    output logic            locked
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam int         SIGW   = 4*CNTW;

    // Timebase and measurements
    logic [CNTW-1:0]            hcnt, vcnt, hlen, vlen;
    logic                       field;
    logic                       lhbl_l, lvbl_l, hs_l, vs_l;
    logic [1:0][CNTW-1:0]       hs_pos, hs_len, vs_hpos, vs_vpos, vs_len;
    logic [1:0][SIGW-1:0]       ref_sig;
    logic [3:0]                 match_cnt, match_nxt;
    logic                       locked_nxt;

    // Generators and output selection
    logic                       hs_gen, vs_gen, hs_gen_nxt, vs_gen_nxt;
    logic [CNTW-1:0]            hs_hold, vs_hold, hs_hold_nxt, vs_hold_nxt;
    logic                       hs_sel, vs_sel, hs_sel_nxt, vs_sel_nxt;

    logic                       hs_n, vs_n, pol_change;
    logic                       hb_edge, vb_edge;
    logic                       hs_lead, hs_trail, vs_lead, vs_trail;
    logic signed [CNTW+1:0]     hoff_ext, voff_ext;
    logic [CNTW-1:0]            htrip, vs_htrip, vs_vtrip;
    logic [CNTW-1:0]            hs_pos_f, hs_len_f, vs_vpos_f, vs_len_f;
    logic [SIGW-1:0]            closing_sig;

`ifdef JTFRAME_RESYNC_POLDET_EN
    // A signed balance of high vs low samples decides the idle level per axis
    localparam logic signed [CNTW-1:0] BAL_MAX = {1'b0, {(CNTW-1){1'b1}}};
    localparam logic signed [CNTW-1:0] BAL_MIN = {1'b1, {(CNTW-1){1'b0}}};

    logic                   hs_pol, vs_pol, hs_pol_nxt, vs_pol_nxt;
    logic signed [CNTW-1:0] hs_bal, vs_bal;

    function automatic logic signed [CNTW-1:0] bal_step(
        input logic signed [CNTW-1:0] bal,
        input logic                   level
    );
        logic signed [CNTW-1:0] r;
        r = bal;
        if (level && bal != BAL_MAX) r = bal + 1'b1;
        else if (!level && bal != BAL_MIN) r = bal - 1'b1;
        return r;
    endfunction

    assign hs_n       = hs_in ^ hs_pol;
    assign vs_n       = vs_in ^ vs_pol;
    assign hs_pol_nxt = !hs_bal[CNTW-1] && hs_bal != '0;
    assign vs_pol_nxt = !vs_bal[CNTW-1] && vs_bal != '0;
    assign pol_change = vb_edge && (hs_pol_nxt != hs_pol || vs_pol_nxt != vs_pol);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pol <= 1'b0;
            vs_pol <= 1'b0;
            hs_bal <= '0;
            vs_bal <= '0;
        end else if (vb_edge) begin
            hs_pol <= hs_pol_nxt;
            vs_pol <= vs_pol_nxt;
            hs_bal <= '0;
            vs_bal <= '0;
        end else if (pxl_cen) begin
            hs_bal <= bal_step(hs_bal, hs_in);
            vs_bal <= bal_step(vs_bal, vs_in);
        end
    end
`else
    assign hs_n       = hs_in;
    assign vs_n       = vs_in;
    assign pol_change = 1'b0;
`endif

    // Extra headroom bit so pos+offset can never overflow before wrapping
    function automatic logic [CNTW-1:0] wrap_trip(
        input logic [CNTW-1:0]        pos,
        input logic signed [CNTW+1:0] off,
        input logic [CNTW-1:0]        len
    );
        logic signed [CNTW+1:0] t, l;
        t = $signed({2'b00, pos}) + off;
        l = $signed({2'b00, len});
        if (len == '0) t = $signed({2'b00, pos});
        else if (t[CNTW+1]) t = t + l;
        else if (t >= l) t = t - l;
        return t[CNTW-1:0];
    endfunction

    assign hb_edge  = pxl_cen & LHBL & ~lhbl_l;
    assign vb_edge  = pxl_cen & LVBL & ~lvbl_l;
    assign hs_lead  = pxl_cen &  hs_n & ~hs_l;
    assign hs_trail = pxl_cen & ~hs_n &  hs_l;
    assign vs_lead  = pxl_cen &  vs_n & ~vs_l;
    assign vs_trail = pxl_cen & ~vs_n &  vs_l;

    assign hs_pos_f    = hs_pos[field];
    assign hs_len_f    = hs_len[field];
    assign vs_vpos_f   = vs_vpos[field];
    assign vs_len_f    = vs_len[field];
    assign closing_sig = {hs_pos_f, hs_len_f, vs_vpos_f, vs_len_f};

    always_comb begin
        hoff_ext = (CNTW+2)'($signed(hoffset));
        if (hres_mode) hoff_ext = hoff_ext <<< HRES_SHIFT;
        voff_ext = (CNTW+2)'($signed(voffset));
    end

    assign htrip    = wrap_trip(hs_pos_f, hoff_ext, hlen);
    assign vs_vtrip = wrap_trip(vs_vpos_f, voff_ext, vlen);
    assign vs_htrip = vs_hpos[field];

    // Pulse generators: a trip loads the width, hold counts it down
    always_comb begin
        hs_gen_nxt  = hs_gen;
        hs_hold_nxt = hs_hold;
        vs_gen_nxt  = vs_gen;
        vs_hold_nxt = vs_hold;
        if (pxl_cen) begin
            if (hcnt == htrip) begin
                hs_gen_nxt  = 1'b1;
                hs_hold_nxt = (hs_len_f == '0) ? '0 : hs_len_f - 1'b1;
            end else if (hs_hold != '0) begin
                hs_hold_nxt = hs_hold - 1'b1;
            end else begin
                hs_gen_nxt = 1'b0;
            end
            if (hcnt == vs_htrip) begin
                if (vcnt == vs_vtrip) begin
                    vs_gen_nxt  = 1'b1;
                    vs_hold_nxt = (vs_len_f == '0) ? '0 : vs_len_f - 1'b1;
                end else if (vs_hold != '0) begin
                    vs_hold_nxt = vs_hold - 1'b1;
                end else begin
                    vs_gen_nxt = 1'b0;
                end
            end
        end
    end

    // Lock detector: the closing field must repeat its previous-frame signature
    always_comb begin
        match_nxt  = match_cnt;
        locked_nxt = locked;
        if (vb_edge) begin
            if (closing_sig == ref_sig[field]) begin
                if (match_cnt != LOCK_N) match_nxt = match_cnt + 4'd1;
                if (match_nxt == LOCK_N) locked_nxt = 1'b1;
            end else begin
                match_nxt  = '0;
                locked_nxt = 1'b0;
            end
            if (pol_change) begin
                match_nxt  = '0;
                locked_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        hs_sel_nxt = hs_sel;
        vs_sel_nxt = vs_sel;
        if (pxl_cen) begin
            hs_sel_nxt = locked_nxt ? hs_gen_nxt : hs_n;
            vs_sel_nxt = locked_nxt ? vs_gen_nxt : vs_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            hlen      <= '0;
            vlen      <= '0;
            field     <= 1'b0;
            lhbl_l    <= 1'b0;
            lvbl_l    <= 1'b0;
            hs_l      <= 1'b0;
            vs_l      <= 1'b0;
            hs_pos    <= '0;
            hs_len    <= '0;
            vs_hpos   <= '0;
            vs_vpos   <= '0;
            vs_len    <= '0;
            ref_sig   <= '0;
        end else if (pxl_cen) begin
            lhbl_l <= LHBL;
            lvbl_l <= LVBL;
            hs_l   <= hs_n;
            vs_l   <= vs_n;
            if (hb_edge) begin
                hcnt <= '0;
                hlen <= hcnt + 1'b1;
            end else if (hcnt != '1) begin
                hcnt <= hcnt + 1'b1;
            end
            if (vb_edge) begin
                vcnt           <= '0;
                vlen           <= vcnt + 1'b1;
                ref_sig[field] <= closing_sig;
                if (FIELDS == 2) field <= ~field;
            end else if (hb_edge && vcnt != '1) begin
                vcnt <= vcnt + 1'b1;
            end
            if (hs_lead) hs_pos[field] <= hcnt;
            if (hs_trail) hs_len[field] <= hcnt - hs_pos_f;
            if (vs_lead) begin
                vs_hpos[field] <= hcnt;
                vs_vpos[field] <= vcnt;
            end
            if (vs_trail) vs_len[field] <= vcnt - vs_vpos_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_gen    <= 1'b0;
            vs_gen    <= 1'b0;
            hs_hold   <= '0;
            vs_hold   <= '0;
            hs_sel    <= 1'b0;
            vs_sel    <= 1'b0;
            match_cnt <= '0;
            locked    <= 1'b0;
            hs_out    <= out_pol;
            vs_out    <= out_pol;
        end else begin
            hs_gen    <= hs_gen_nxt;
            vs_gen    <= vs_gen_nxt;
            hs_hold   <= hs_hold_nxt;
            vs_hold   <= vs_hold_nxt;
            hs_sel    <= hs_sel_nxt;
            vs_sel    <= vs_sel_nxt;
            match_cnt <= match_nxt;
            locked    <= locked_nxt;
            hs_out    <= hs_sel_nxt ^ out_pol;
            vs_out    <= vs_sel_nxt ^ out_pol;
        end
    end

endmodule

// File: tb/tb_jtframe_resync_gen.sv
// Bench for jtframe_resync_gen: a reduced 64x24 frame, bypass and locked regimes,
// signed offset wrap, output polarity, timing change and mid-line reset.
module tb_jtframe_resync_gen;

    localparam int BITS = 4;
    localparam int CNTW = 10;
    localparam int HTOT = 64;
    localparam int VTOT = 24;
    localparam int HACT = 48;
    localparam int VACT = 20;

    logic            clk = 1'b0;
    logic            rst, pxl_cen, hs_in, vs_in, LHBL, LVBL;
    logic [BITS-1:0] hoffset, voffset;
    logic            hres_mode, out_pol;
    logic            hs_out, vs_out, locked;

    jtframe_resync_gen #(
        .BITS(BITS), .CNTW(CNTW), .FIELDS(2), .HRES_SHIFT(1), .LOCK_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .hs_in(hs_in), .vs_in(vs_in), .LHBL(LHBL), .LVBL(LVBL),
        .hoffset(hoffset), .voffset(voffset), .hres_mode(hres_mode),
        .out_pol(out_pol), .hs_out(hs_out), .vs_out(vs_out), .locked(locked)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int frame_no = 0;
    // input timing and effective offsets (pixels / lines)
    int hs_x, hs_w, vs_y, vs_w, hoff_eff, voff_eff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input int p, input int start, input int len, input int tot);
        int d;
        d = ((p - start) % tot + tot) % tot;
        return d < len;
    endfunction

    // One pixel: drive inputs with cen, push the expected outputs, compare after the edge
    task automatic drive_pixel(input int x, input int y, input bit cmp, input bit lk);
        logic       hsv, vsv;
        logic [1:0] e;
        @(negedge clk);
        hsv     = in_win(x, hs_x, hs_w, HTOT);
        vsv     = in_win(y, vs_y, vs_w, VTOT);
        hs_in   = hsv;
        vs_in   = vsv;
        LHBL    = (x < HACT);
        LVBL    = (y < VACT);
        pxl_cen = 1'b1;
        if (cmp) begin
            if (lk)
                e = {in_win(x, hs_x + hoff_eff, hs_w, HTOT),
                     in_win(y*HTOT + x, (vs_y + voff_eff)*HTOT, vs_w*HTOT, HTOT*VTOT)};
            else
                e = {hsv, vsv};
            exp_q.push_back(e ^ {out_pol, out_pol});
        end
        @(posedge clk);
        #1;
        pxl_cen = 1'b0;
        if (cmp) begin
            if (exp_q.size() == 0) begin
                check("queue_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("hs f%0d x%0d y%0d", frame_no, x, y), {31'b0, hs_out}, {31'b0, e[1]});
                check($sformatf("vs f%0d x%0d y%0d", frame_no, x, y), {31'b0, vs_out}, {31'b0, e[0]});
            end
        end
        if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input bit cmp, input bit lk);
        for (int y = 0; y < VTOT; y++)
            for (int x = 0; x < HTOT; x++)
                drive_pixel(x, y, cmp, lk);
        frame_no++;
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        LHBL = 1'b0; LVBL = 1'b0; hoffset = '0; voffset = '0;
        hres_mode = 1'b0; out_pol = 1'b0;
        hs_x = 40; hs_w = 8; vs_y = 16; vs_w = 3; hoff_eff = 0; voff_eff = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hs_out", {31'b0, hs_out}, 32'd0);
        check("rst_vs_out", {31'b0, vs_out}, 32'd0);
        check("rst_locked", {31'b0, locked}, 32'd0);
        @(negedge clk) out_pol = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hs_pol1", {31'b0, hs_out}, 32'd1);
        check("rst_vs_pol1", {31'b0, vs_out}, 32'd1);
        @(negedge clk) begin out_pol = 1'b0; rst = 1'b0; end

        // Unlocked: outputs follow inputs with one cen of delay
        run_frame(1'b1, 1'b0);
        repeat (7) run_frame(1'b0, 1'b0);
        check("lock_acquired", {31'b0, locked}, 32'd1);
        run_frame(1'b1, 1'b1);

        // Negative offset scaled by hres_mode; positive vertical shift
        hoffset = 4'b1000; hres_mode = 1'b1; hoff_eff = -16;
        voffset = 4'd5; voff_eff = 5;
        run_frame(1'b1, 1'b1);
        check("lock_hold_offset", {31'b0, locked}, 32'd1);

        // Inverted output polarity, negative vertical shift
        out_pol = 1'b1; hoffset = 4'd3; hres_mode = 1'b0; hoff_eff = 3;
        voffset = 4'b1000; voff_eff = -8;
        run_frame(1'b1, 1'b1);
        out_pol = 1'b0; hoffset = '0; voffset = '0; hoff_eff = 0; voff_eff = 0;
        run_frame(1'b0, 1'b1);

        // Timing change: lock drops, bypass, then relock with wrapping offsets
        hs_x = 60; hs_w = 4; vs_y = 2; vs_w = 3;
        hoffset = 4'd7; hoff_eff = 7; voffset = 4'b1000; voff_eff = -8;
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b0);
        check("lock_dropped", {31'b0, locked}, 32'd0);
        repeat (6) run_frame(1'b0, 1'b0);
        check("relock", {31'b0, locked}, 32'd1);
        run_frame(1'b1, 1'b1);

        // Mid-line reset while the regenerated HS is high
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < HTOT; x++)
                drive_pixel(x, y, 1'b1, 1'b1);
        for (int x = 0; x < 5; x++)
            drive_pixel(x, 5, 1'b1, 1'b1);
        check("pre_rst_hs_out", {31'b0, hs_out}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_hs_out", {31'b0, hs_out}, 32'd0);
        check("mid_rst_vs_out", {31'b0, vs_out}, 32'd0);
        check("mid_rst_locked", {31'b0, locked}, 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int x = 5; x < HTOT; x++)
            drive_pixel(x, 5, 1'b1, 1'b0);
        for (int y = 6; y < VTOT; y++)
            for (int x = 0; x < HTOT; x++)
                drive_pixel(x, y, 1'b1, 1'b0);
        frame_no++;
        repeat (7) run_frame(1'b0, 1'b0);
        check("relock_after_rst", {31'b0, locked}, 32'd1);
        run_frame(1'b1, 1'b1);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
